// File: rtl/pipe_add.sv
// Pipelined two-operand adder/subtractor. The carry chain is cut into STAGES equal
// segments, one per stage. Optional output saturation is enabled with PIPE_ADD_SAT_EN.
module pipe_add #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  input  logic             cin,
`ifdef PIPE_ADD_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d, c_q, c_d, ld_c;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_v, src_c;
  logic [SEG:0]      seg_c [STAGES];
  logic [WIDTH-1:0]  res_c;
  logic              msb_cin_c, ovf_raw_c;
`ifdef PIPE_ADD_SAT_EN
  logic [STAGES-1:0] sat_q, sat_d, src_sat;
`endif

  always_comb begin
    logic acc;
    acc = out_ready;
    ld_c = '0;
    // A stage may load if it or any stage downstream of it has a free slot.
    for (int k = int'(LAST); k >= 0; k--) begin
      acc = acc || !v_q[k];
      ld_c[k] = acc;
    end

    src_v[0] = in_valid;
    src_a[0] = in0;
    src_b[0] = sub ? ~in1 : in1;
    src_c[0] = sub | cin;
    src_s[0] = '0;
`ifdef PIPE_ADD_SAT_EN
    src_sat[0] = sat;
`endif
    for (int k = 1; k < int'(STAGES); k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
`ifdef PIPE_ADD_SAT_EN
      src_sat[k] = sat_q[k-1];
`endif
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      seg_c[k] = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
               + (SEG+1)'(src_c[k]);
      v_d[k] = ld_c[k] ? src_v[k] : v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
`ifdef PIPE_ADD_SAT_EN
      sat_d[k] = sat_q[k];
`endif
      if (ld_c[k] && src_v[k]) begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
        s_d[k] = src_s[k];
        s_d[k][k*SEG +: SEG] = seg_c[k][SEG-1:0];
        c_d[k] = seg_c[k][SEG];
`ifdef PIPE_ADD_SAT_EN
        sat_d[k] = src_sat[k];
`endif
      end
    end

    // Last stage also derives the overflow flag and applies the optional clamp.
    res_c = src_s[LAST];
    res_c[LAST*SEG +: SEG] = seg_c[LAST][SEG-1:0];
    msb_cin_c = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ res_c[WIDTH-1];
    ovf_raw_c = msb_cin_c ^ seg_c[LAST][SEG];
`ifdef PIPE_ADD_SAT_EN
    if (src_sat[LAST] && ovf_raw_c) begin
      res_c = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    ovf_d = ovf_q;
    if (ld_c[LAST] && src_v[LAST]) begin
      s_d[LAST] = res_c;
      ovf_d = ovf_raw_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
`ifdef PIPE_ADD_SAT_EN
      sat_q <= '0;
`endif
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
`ifdef PIPE_ADD_SAT_EN
      sat_q <= sat_d;
`endif
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = ld_c[0];
  assign out_valid = v_q[LAST];
  assign out       = s_q[LAST];
  assign carry     = c_q[LAST];
  assign ovf       = ovf_q;

endmodule
